// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, IV, round functions and the
// compression-block state encoding.
package sha256_pkg;

   localparam int ROUNDS = 64;
   localparam int IDX_W  = 6;

   typedef logic [31:0] word_t;

   // Working variables a..h; a lands in [255:224] to match the {H0..H7} layout.
   typedef struct packed {
      word_t a;
      word_t b;
      word_t c;
      word_t d;
      word_t e;
      word_t f;
      word_t g;
      word_t h;
   } work_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2,
      ST_DONE = 2'd3
   } cmp_state_e;

   localparam logic [0:63][31:0] K_TABLE = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Rotations are written as fixed slices so they cost only wiring.
   function automatic word_t big_sigma0(input word_t x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic word_t big_sigma1(input word_t x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic word_t small_sigma0(input word_t x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic word_t small_sigma1(input word_t x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
   endfunction

   function automatic word_t ch(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic word_t maj(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   // Eight independent 32-bit modular adds (chaining-value feed-forward).
   function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      r = 256'd0;
      for (int i = 0; i < 8; i++) begin
         r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      end
      return r;
   endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// One purely combinational SHA-256 compression round. Kept stand-alone so the
// unrolled pipeline variants can instantiate it directly.
module sha256_round_comb
   import sha256_pkg::*;
(
   input  work_t state_i,
   input  word_t k_i,
   input  word_t w_i,
   output work_t state_o
);

   word_t t1_s;
   word_t t2_s;

   // Compute T1/T2 and shift the working variables down by one position.
   always_comb begin
      t1_s = state_i.h + big_sigma1(state_i.e) + ch(state_i.e, state_i.f, state_i.g)
             + k_i + w_i;
      t2_s = big_sigma0(state_i.a) + maj(state_i.a, state_i.b, state_i.c);
      state_o.a = t1_s + t2_s;
      state_o.b = state_i.a;
      state_o.c = state_i.b;
      state_o.d = state_i.c;
      state_o.e = state_i.d + t1_s;
      state_o.f = state_i.e;
      state_o.g = state_i.f;
      state_o.h = state_i.g;
   end

endmodule

// File: rtl/sha256_compress_stream.sv
// Streaming SHA-256 compression: takes a chaining value, then one schedule
// word per accepted beat, and presents the 256-bit digest on valid/ready.
module sha256_compress_stream
   import sha256_pkg::*;
(
   input  logic         CLK,
   input  logic         RST,
   input  logic         clear,
   input  logic         init_valid,
   output logic         init_ready,
   input  logic [255:0] h_in,
   input  logic         w_valid,
   output logic         w_ready,
   input  logic [31:0]  w_in,
   output logic [5:0]   round_idx,
   output logic         digest_valid,
   input  logic         digest_ready,
   output logic [255:0] digest_out
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   cmp_state_e       state_q;
   work_t            work_q;
   work_t            work_d;
   logic [255:0]     hcopy_q;
   logic [IDX_W-1:0] t_q;
   logic [255:0]     digest_q;
   logic             dvalid_q;

   sha256_round_comb u_round (
      .state_i (work_q),
      .k_i     (K_TABLE[t_q]),
      .w_i     (w_in),
      .state_o (work_d)
   );

   // Handshake readiness is a pure decode of the state register, so it
   // follows the asynchronous reset without needing a clock edge.
   assign init_ready   = (state_q == ST_IDLE);
   assign w_ready      = (state_q == ST_RUN);
   assign round_idx    = t_q;
   assign digest_valid = dvalid_q;
   assign digest_out   = digest_q;

   // Control FSM plus working, chaining-copy, round-counter and digest registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         work_q   <= '0;
         hcopy_q  <= 256'd0;
         t_q      <= '0;
         digest_q <= 256'd0;
         dvalid_q <= 1'b0;
      end else if (clear) begin
         // Abort: data registers keep stale contents, they are reloaded on init.
         state_q  <= ST_IDLE;
         t_q      <= '0;
         dvalid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (init_valid) begin
                  hcopy_q <= h_in;
                  work_q  <= h_in;
                  t_q     <= '0;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_valid) begin
                  work_q <= work_d;
                  t_q    <= t_q + IDX_ONE;
                  if (t_q == LAST_IDX) begin
                     state_q <= ST_FIN;
                  end
               end
            end
            ST_FIN: begin
               digest_q <= add_words(hcopy_q, work_q);
               dvalid_q <= 1'b1;
               state_q  <= ST_DONE;
            end
            ST_DONE: begin
               if (digest_ready) begin
                  dvalid_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            default: begin
               dvalid_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
